// File: rtl/shift_sequencer.sv
// Multi-cycle arithmetic shifter: accepts one request, shifts one bit per clock,
// and reports the result with a single-cycle done pulse.
//   state   | meaning
//   IDLE    | ready for a request
//   SHIFT   | shifting one bit per cycle, counter running down
//   DONE    | result valid in o_d_out, one-cycle pulse
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_sh_dir,
    input  logic [AMT_W-1:0] i_sh_amt,
    input  logic [WIDTH-1:0] i_d_in,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_d_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_work;
    logic             r_dir;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_d_out;

    logic [WIDTH-1:0] w_shifted;
    logic [CNT_W-1:0] w_cnt_load;

    assign w_shifted = r_dir ? {r_work[WIDTH-2:0], 1'b0}
                             : {r_work[WIDTH-1], r_work[WIDTH-1:1]};

    // Amounts at or beyond the data width saturate; the result is then all
    // sign bits (right) or all zeros (left) after WIDTH single-bit steps.
    always_comb begin
        w_cnt_load = CNT_W'(WIDTH);
        if (32'(i_sh_amt) < WIDTH)
            w_cnt_load = CNT_W'(i_sh_amt);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_dir   <= 1'b0;
            r_cnt   <= '0;
            r_d_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_work <= i_d_in;
                        r_dir  <= i_sh_dir;
                        r_cnt  <= w_cnt_load;
                        if (w_cnt_load == '0) begin
                            r_d_out <= i_d_in;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (i_abort) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_work <= w_shifted;
                        r_cnt  <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_d_out <= w_shifted;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready = (r_state == S_IDLE);
    assign o_busy  = (r_state == S_SHIFT);
    assign o_done  = (r_state == S_DONE);
    assign o_d_out = r_d_out;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized
// requests compared against an arithmetic reference model.
module tb_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic        i_abort;
    logic        i_sh_dir;
    logic [5:0]  i_sh_amt;
    logic [31:0] i_d_in;
    logic        o_ready;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_d_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_dout = '0;

    shift_sequencer #(.WIDTH(32), .AMT_W(6)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (i_start),
        .i_abort (i_abort),
        .i_sh_dir(i_sh_dir),
        .i_sh_amt(i_sh_amt),
        .i_d_in  (i_d_in),
        .o_ready (o_ready),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_d_out (o_d_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic dir, input int n, input logic [31:0] d);
        if (dir)
            return (n >= 32) ? 32'h0 : (d << n);
        else
            return (n >= 32) ? {32{d[31]}} : 32'($signed(d) >>> n);
    endfunction

    // One request from issue to return-to-idle; abort_c >= 0 aborts at that SHIFT cycle.
    task automatic do_op(input logic dir, input logic [5:0] amt, input logic [31:0] d,
                         input int abort_c, input bit noise, input string nm);
        int n;
        logic [31:0] exp;
        n   = (amt > 6'd32) ? 32 : int'(amt);
        exp = model(dir, n, d);
        n_tests++;
        if (o_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before_issue got %b want 1", nm, o_ready);
        end
        i_start  = 1'b1;
        i_sh_dir = dir;
        i_sh_amt = amt;
        i_d_in   = d;
        i_abort  = noise && (abort_c < 0);
        @(posedge clk); #1;
        i_abort = 1'b0;
        i_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noise) begin
            i_d_in   = $urandom;
            i_sh_dir = 1'($urandom);
            i_sh_amt = 6'($urandom);
        end
        for (int c = 0; c <= n; c++) begin
            n_tests++;
            if (o_busy !== (c < n) || o_done !== (c == n) || o_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s flags cycle %0d got busy=%b done=%b ready=%b want busy=%b done=%b ready=0",
                         nm, c, o_busy, o_done, o_ready, c < n, c == n);
            end
            n_tests++;
            if (o_d_out !== ((c == n) ? exp : exp_dout)) begin
                n_fail++;
                $display("FAIL %s d_out cycle %0d got %h want %h", nm, c, o_d_out,
                         (c == n) ? exp : exp_dout);
            end
            if (c == abort_c && c < n) begin
                i_abort = 1'b1;
                @(posedge clk); #1;
                i_abort = 1'b0;
                i_start = 1'b0;
                n_tests++;
                if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_d_out !== exp_dout) begin
                    n_fail++;
                    $display("FAIL %s after_abort got ready=%b busy=%b done=%b d_out=%h want 1 0 0 %h",
                             nm, o_ready, o_busy, o_done, o_d_out, exp_dout);
                end
                return;
            end
            if (c == n && noise) i_abort = 1'b1;
            @(posedge clk); #1;
            if (noise && c < n) begin
                i_start = 1'($urandom_range(0, 1));
                i_d_in  = $urandom;
            end
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        exp_dout = exp;
        n_tests++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_d_out !== exp) begin
            n_fail++;
            $display("FAIL %s after_done got ready=%b busy=%b done=%b d_out=%h want 1 0 0 %h",
                     nm, o_ready, o_busy, o_done, o_d_out, exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_sh_dir = 1'b0; i_sh_amt = '0; i_d_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_d_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset got ready=%b busy=%b done=%b d_out=%h want 1 0 0 0",
                     o_ready, o_busy, o_done, o_d_out);
        end
        exp_dout = '0;
    endtask

    task automatic test_directed;
        do_op(1'b0, 6'd4,  32'h8000_0000, -1, 1'b0, "right4");
        n_tests++;
        if (exp_dout !== 32'hF800_0000 || o_d_out !== 32'hF800_0000) begin
            n_fail++;
            $display("FAIL right4_value got %h want f8000000", o_d_out);
        end
        do_op(1'b1, 6'd31, 32'h0000_0001, -1, 1'b0, "left31");
        n_tests++;
        if (o_d_out !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL left31_value got %h want 80000000", o_d_out);
        end
        do_op(1'b0, 6'd0,  32'h1234_5678, -1, 1'b0, "zero_amt");
        do_op(1'b1, 6'd0,  32'hCAFE_F00D, -1, 1'b1, "zero_amt_noise");
    endtask

    task automatic test_clamp;
        do_op(1'b0, 6'd40, 32'h8000_0000, -1, 1'b0, "clamp_right");
        n_tests++;
        if (o_d_out !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL clamp_right_value got %h want ffffffff", o_d_out);
        end
        do_op(1'b1, 6'd40, 32'hFFFF_FFFF, -1, 1'b0, "clamp_left");
        n_tests++;
        if (o_d_out !== 32'h0) begin
            n_fail++;
            $display("FAIL clamp_left_value got %h want 0", o_d_out);
        end
        do_op(1'b0, 6'd32, 32'h7FFF_0000, -1, 1'b0, "amt_eq_width");
        do_op(1'b1, 6'd63, 32'h1357_9BDF, -1, 1'b0, "amt_max");
    endtask

    task automatic test_ignore_start_and_abort;
        do_op(1'b1, 6'd8, 32'h00A5_5A01, -1, 1'b1, "start_ignored");
        do_op(1'b0, 6'd8, 32'h9ABC_DEF0,  4, 1'b0, "abort_c4");
        do_op(1'b0, 6'd1, 32'h8765_4321,  0, 1'b0, "abort_last_shift");
        do_op(1'b1, 6'd3, 32'h0F0F_0F0F, -1, 1'b0, "after_abort");
    endtask

    task automatic test_reset_mid;
        i_start = 1'b1; i_sh_dir = 1'b0; i_sh_amt = 6'd10; i_d_in = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0 || o_d_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid got ready=%b busy=%b done=%b d_out=%h want 1 0 0 0",
                     o_ready, o_busy, o_done, o_d_out);
        end
        #1 rst = 1'b0;
        exp_dout = '0;
        @(posedge clk); #1;
        do_op(1'b1, 6'd2, 32'h4000_0003, -1, 1'b0, "after_reset_mid");
    endtask

    task automatic test_random;
        for (int k = 0; k < 40; k++) begin
            logic [5:0] amt;
            int n;
            int ab;
            amt = 6'($urandom_range(0, 40));
            n   = (amt > 6'd32) ? 32 : int'(amt);
            ab  = -1;
            if (n > 0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(0, n - 1));
            do_op(1'($urandom), amt, $urandom, ab, 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_clamp;
        test_ignore_start_and_abort;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
